relu_grad_gate: RTL and testbench

RELU_GRAD_GATE -- requirements
Module: relu_grad_gate

---
 rtl/relu_grad_gate.sv | 135 +++++++++++++
 tb/tb_relu_grad_gate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_grad_gate.sv
// Purpose: gates backward gradients with the ReLU mask recorded on the forward pass.
//   Each forward word pushes the bit (x > 0) into a mask FIFO. Each gradient pops
//   the oldest bit and is passed through or zeroed.
// Latency: 1 cycle from gradient acceptance to out_valid/out_data.
// Backpressure: fwd_ready drops when the mask FIFO is full. grad_ready drops when the
//   FIFO is empty or when the output register is held by out_ready low.
//
// Ports:
//   clk, rst        single clock; asynchronous active-high reset
//   flush           synchronous clear of the mask FIFO, output stage and ovf_err
//   fwd_valid/fwd_ready/fwd_data     forward pre-activation stream (mask producer)
//   grad_valid/grad_ready/grad_data  upstream gradient stream (mask consumer)
//   out_valid/out_ready/out_data     gated gradient stream
//   mask_count      number of stored mask bits (0..MASK_DEPTH)
//   ovf_err         sticky: a forward word was offered while the FIFO was full
module relu_grad_gate #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         fwd_valid,
  input  logic signed [DATA_WIDTH-1:0] fwd_data,
  output logic                         fwd_ready,
  input  logic                         grad_valid,
  input  logic signed [DATA_WIDTH-1:0] grad_data,
  output logic                         grad_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH:0]          mask_count,
  output logic                         ovf_err
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(MASK_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  // Mask storage: one bit per forward word. Not reset; only entries written
  // since the last reset/flush are ever read, because reads are gated by count.
  logic                  mask_mem [MASK_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;

  logic full;
  logic empty;
  logic fwd_pos;
  logic fwd_fire;
  logic grad_fire;
  logic mask_bit;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // Ready depends only on registered state (and out_ready), so a push into an
  // empty FIFO becomes visible to the gradient side one cycle later, and a full
  // FIFO refuses a push even if a pop happens in the same cycle.
  assign fwd_ready  = !full;
  assign grad_ready = !empty && (!out_valid || out_ready);

  // flush discards any handshake that lands in the same cycle.
  assign fwd_fire  = fwd_valid  && fwd_ready  && !flush;
  assign grad_fire = grad_valid && grad_ready && !flush;

  // Strictly positive: sign bit clear and not zero.
  assign fwd_pos  = !fwd_data[DATA_WIDTH-1] && (fwd_data != '0);
  assign mask_bit = mask_mem[rd_ptr];

  assign mask_count = cnt;

  always_ff @(posedge clk) begin
    if (fwd_fire) begin
      mask_mem[wr_ptr] <= fwd_pos;
    end
  end

  // Pointers and occupancy. Pointers are exactly ADDR_WIDTH bits, so they wrap
  // from MASK_DEPTH-1 to 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (fwd_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (grad_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({fwd_fire, grad_fire})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Output register. A new gradient may only be accepted when the register is
  // empty or being drained this cycle (see grad_ready), so loading on grad_fire
  // never overwrites an untransferred word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (grad_fire) begin
      out_valid <= 1'b1;
      out_data  <= mask_bit ? grad_data : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow: any forward offer refused because the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
    end else if (fwd_valid && !fwd_ready) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_relu_grad_gate.sv
// Purpose: scoreboard bench for relu_grad_gate with a queue-based reference model.
// Latency: n/a.
// Backpressure: random out_ready stalls and forward/gradient offers.
module tb_relu_grad_gate;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 fwd_valid = 1'b0;
  logic signed [DW-1:0] fwd_data = '0;
  logic                 grad_valid = 1'b0;
  logic signed [DW-1:0] grad_data = '0;
  logic                 out_ready = 1'b0;
  logic                 fwd_ready;
  logic                 grad_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [AW:0]          mask_count;
  logic                 ovf_err;

  relu_grad_gate #(.DATA_WIDTH(DW), .MASK_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data),
    .fwd_ready  (fwd_ready),
    .grad_valid (grad_valid),
    .grad_data  (grad_data),
    .grad_ready (grad_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .mask_count (mask_count),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of mask bits, expected-output scoreboard, and the
  // expected output-valid / overflow flags.
  bit mq[$];
  int sb[$];
  int olog[$];
  bit mv   = 1'b0;
  bit movf = 1'b0;
  bit mon_en = 1'b0;
  bit hold_pend = 1'b0;
  int hold_dat  = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    mv   = 1'b0;
    movf = 1'b0;
  endtask

  // One clock cycle: drive inputs after the edge, check state and readies at
  // the falling edge, then advance the model by what the next edge will accept.
  task automatic cyc(input bit fv, input logic signed [DW-1:0] fd,
                     input bit gv, input logic signed [DW-1:0] gd,
                     input bit ordy, input bit fl);
    bit efr;
    bit egr;
    bit m;
    @(posedge clk);
    #1;
    fwd_valid  = fv;
    fwd_data   = fd;
    grad_valid = gv;
    grad_data  = gd;
    out_ready  = ordy;
    flush      = fl;
    @(negedge clk);
    efr = (mq.size() < DEPTH);
    egr = (mq.size() != 0) && (!mv || ordy);
    chk("fwd_ready",  fwd_ready,  int'(efr));
    chk("grad_ready", grad_ready, int'(egr));
    chk("out_valid",  out_valid,  int'(mv));
    chk("mask_count", mask_count, mq.size());
    chk("ovf_err",    ovf_err,    int'(movf));
    chk("count_le_depth", int'(mask_count <= DEPTH), 1);
    if (fl) begin
      model_reset();
    end else begin
      if (fv && !efr) movf = 1'b1;
      if (gv && egr) begin
        m = mq.pop_front();
        sb.push_back(m ? int'(gd) : 0);
        mv = 1'b1;
      end else if (ordy) begin
        mv = 1'b0;
      end
      if (fv && efr) mq.push_back(fd > 0);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks that a
  // stalled output holds its value.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data",  out_data,  hold_dat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got output %0d expected none", out_data);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
        olog.push_back(int'(out_data));
      end
      hold_pend = out_valid && !out_ready && !flush;
      hold_dat  = int'(out_data);
    end
  end

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
      cyc(1'b0, '0, 1'b1, DW'($urandom), 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic signed [DW-1:0] rf;
    logic signed [DW-1:0] rg;
    int pf;
    int pg;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_count",     mask_count, 0);
    chk("rst_ovf",       ovf_err,   0);
    #2;
    rst = 1'b0;
    mon_en = 1'b1;

    // Empty FIFO refuses gradients; a push is visible one cycle later only.
    cyc(1'b0, '0, 1'b1, 16'sd99, 1'b1, 1'b0);
    cyc(1'b1, 16'sd1, 1'b1, 16'sd99, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'sd55, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Directed gating example
    cyc(1'b1, 16'sd5,  1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, -16'sd3, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'sd0,  1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'sd7,  1'b0, '0, 1'b1, 1'b0);
    olog.delete();
    cyc(1'b0, '0, 1'b1, 16'sd10, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'sd20, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'sd30, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'sd40, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("ex_count", olog.size(), 4);
    if (olog.size() == 4) begin
      chk("ex_out0", olog[0], 10);
      chk("ex_out1", olog[1], 0);
      chk("ex_out2", olog[2], 0);
      chk("ex_out3", olog[3], 40);
    end

    // Output stall with three stored masks
    cyc(1'b1, 16'sd2, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'sd3, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 16'sd4, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, -16'sd8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 16'sd5, 1'b0, 1'b0);
      chk("stall_data",  out_data,   -8);
      chk("stall_count", mask_count, 2);
      chk("stall_grdy",  grad_ready, 0);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Fill to full, then offer one more
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DW'(i + 1), 1'b0, '0, 1'b1, 1'b0);
    end
    cyc(1'b1, 16'sd9, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("full_count", mask_count, DEPTH);
    chk("ovf_held",   ovf_err,    1);

    // Drain to 6, pop one into a stalled output, then flush
    for (int i = 0; i < DEPTH - 6; i++) begin
      cyc(1'b0, '0, 1'b1, DW'($urandom), 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 16'sd7, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_flush_count", mask_count, 5);
    chk("pre_flush_valid", out_valid,  1);
    cyc(1'b1, 16'sd3, 1'b1, 16'sd4, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("flush_out_data", out_data,  0);
    chk("flush_fwd_rdy",  fwd_ready, 1);
    chk("flush_ovf",      ovf_err,   0);

    // Random interleaving across several pointer wraps
    for (int i = 0; i < 6 * DEPTH; i++) begin
      pf = (i < 3 * DEPTH) ? 70 : 40;
      pg = (i < 3 * DEPTH) ? 40 : 70;
      rf = DW'($urandom);
      rg = DW'($urandom);
      if ($urandom_range(0, 7) == 0) rf = '0;
      cyc(($urandom_range(0, 99) < pf), rf, ($urandom_range(0, 99) < pg), rg,
          ($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    // Asynchronous reset with a stalled output and 5 masks stored
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, DW'(i + 1), 1'b0, '0, 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 16'sd21, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count", mask_count, 5);
    chk("pre_rst_valid", out_valid,  1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid,  0);
    chk("arst_out_data",  out_data,   0);
    chk("arst_count",     mask_count, 0);
    chk("arst_ovf",       ovf_err,    0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    cyc(1'b1, 16'sd4, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 16'sd11, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
